// File: rtl/la_scan_pkg.sv
// ============================================================================
//  Module   : la_scan_pkg
//  Purpose  : Shared state encodings and counter-width helper for la_scanctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package la_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CAPT   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int cnt_width(input int n, input int capt);
        return $clog2(n + capt + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/la_scan_shreg.sv
// ============================================================================
//  Module   : la_scan_shreg
//  Purpose  : N-bit loadable right-shift register (serial in at MSB, out at LSB).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module la_scan_shreg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [N-1:0] ld_data,
    input  logic         shift,
    input  logic         si,
    output logic [N-1:0] q,
    output logic         so
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= ld_data;
        end else if (shift) begin
            r_q <= {si, r_q[N-1:1]};
        end
    end

    assign q  = r_q;
    assign so = r_q[0];

endmodule

`default_nettype wire

// File: rtl/la_scanctrl.sv
// ============================================================================
//  Module   : la_scanctrl
//  Purpose  : Scan-chain access controller: load pattern, capture, unload.
//             Optional compare stage enabled by LA_SCANCTRL_COMPARE_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module la_scanctrl
    import la_scan_pkg::*;
#(
    parameter int   N    = 32,
    parameter int   CAPT = 1,
    parameter logic FILL = 1'b0,
    parameter int   CW   = cnt_width(N, CAPT)
) (
    input  logic         clk,
    input  logic         nreset,
`ifdef LA_SCANCTRL_COMPARE_EN
    input  logic [N-1:0] expected,
    input  logic [N-1:0] mask,
    output logic         fail,
`endif
    input  logic         start,
    input  logic [N-1:0] pattern,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] response,
    output logic         scan_se,
    output logic         scan_si,
    input  logic         scan_so
);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_se;
    logic          r_si;
    logic [N-1:0]  r_response;

    logic          w_accept;
    logic          w_ser_shift;
    logic          w_deser_shift;
    logic [N-1:0]  w_ser_q;
    logic          w_ser_so;
    logic [N-1:0]  w_deser_q;
    logic          w_deser_so;
    logic [N-1:0]  w_resp_next;
    logic          w_unused;

    assign w_accept      = (r_state == ST_IDLE) && start;
    assign w_ser_shift   = (r_state == ST_LOAD);
    assign w_deser_shift = (r_state == ST_UNLOAD);
    // Final unload sample joins the deserializer contents on the last edge.
    assign w_resp_next   = {scan_so, w_deser_q[N-1:1]};
    assign w_unused      = ^{w_ser_q, w_deser_so, w_deser_q[0]};

    // pattern[0] goes straight to scan_si on accept, so the shadow holds the rest.
    la_scan_shreg #(.N(N)) u_ser (
        .clk     (clk),
        .nreset  (nreset),
        .load    (w_accept),
        .ld_data ({FILL, pattern[N-1:1]}),
        .shift   (w_ser_shift),
        .si      (FILL),
        .q       (w_ser_q),
        .so      (w_ser_so)
    );

    la_scan_shreg #(.N(N)) u_deser (
        .clk     (clk),
        .nreset  (nreset),
        .load    (1'b0),
        .ld_data ('0),
        .shift   (w_deser_shift),
        .si      (scan_so),
        .q       (w_deser_q),
        .so      (w_deser_so)
    );

`ifdef LA_SCANCTRL_COMPARE_EN
    logic [N-1:0] r_expect;
    logic [N-1:0] r_mask;
    logic         r_fail;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_expect <= '0;
            r_mask   <= '0;
            r_fail   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_expect <= expected;
                r_mask   <= mask;
            end
            if (r_state == ST_UNLOAD && r_cnt == CW'(1)) begin
                r_fail <= |((w_resp_next ^ r_expect) & r_mask);
            end
        end
    end

    assign fail = r_fail;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_se       <= 1'b0;
            r_si       <= 1'b0;
            r_response <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                        r_se    <= 1'b1;
                        r_si    <= pattern[0];
                        r_cnt   <= CW'(N);
                    end
                end
                ST_LOAD: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_CAPT;
                        r_se    <= 1'b0;
                        r_si    <= FILL;
                        r_cnt   <= CW'(CAPT);
                    end else begin
                        r_si    <= w_ser_so;
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                ST_CAPT: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_UNLOAD;
                        r_se    <= 1'b1;
                        r_si    <= FILL;
                        r_cnt   <= CW'(N);
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (r_cnt == CW'(1)) begin
                        r_state    <= ST_DONE;
                        r_se       <= 1'b0;
                        r_done     <= 1'b1;
                        r_response <= w_resp_next;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt      <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_se    <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign response = r_response;
    assign scan_se  = r_se;
    assign scan_si  = r_si;

endmodule

`default_nettype wire

// File: tb/tb_la_scanctrl.sv
// ============================================================================
//  Module   : tb_la_scanctrl
//  Purpose  : Scoreboard bench for la_scanctrl with an 8-flop behavioural chain.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_la_scanctrl;

    localparam int N    = 8;
    localparam int CAPT = 1;
    localparam int LAT  = 2 * N + CAPT;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pattern = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic         scan_se;
    logic         scan_si;
    logic         scan_so;
    logic         cap_inv = 1'b1;
    logic [N-1:0] expected = '0;
    logic [N-1:0] mask = '0;
`ifdef LA_SCANCTRL_COMPARE_EN
    logic         fail;
`endif

    typedef struct {
        logic [N-1:0] resp;
        int           due;
        logic         fl;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   se_hi   = 0;
    int   se_lo   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    la_scanctrl #(.N(N), .CAPT(CAPT), .FILL(1'b0)) dut (
        .clk      (clk),
        .nreset   (nreset),
`ifdef LA_SCANCTRL_COMPARE_EN
        .expected (expected),
        .mask     (mask),
        .fail     (fail),
`endif
        .start    (start),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .response (response),
        .scan_se  (scan_se),
        .scan_si  (scan_si),
        .scan_so  (scan_so)
    );

    // Chain: chain[0] takes scan_si, chain[N-1] drives scan_so.
    logic [N-1:0] chain;
    always @(posedge clk or negedge nreset) begin
        if (!nreset)      chain <= '0;
        else if (scan_se) chain <= {chain[N-2:0], scan_si};
        else              chain <= cap_inv ? ~chain : chain;
    end
    assign scan_so = chain[N-1];

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!nreset) begin
            se_hi = 0;
            se_lo = 0;
        end else begin
            if (busy && !done) begin
                if (scan_se) se_hi++;
                else         se_lo++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("response", int'(response), int'(e.resp));
                    chk("done_cycle", cyc, e.due);
                    chk("se_high_cycles", se_hi, 2 * N);
                    chk("se_low_cycles", se_lo, CAPT);
                    chk("busy_in_done", int'(busy), 1);
`ifdef LA_SCANCTRL_COMPARE_EN
                    chk("fail", int'(fail), int'(e.fl));
`endif
                end
                se_hi = 0;
                se_lo = 0;
            end
        end
    end

    task automatic push_exp(input logic [N-1:0] p, input logic [N-1:0] ex,
                            input logic [N-1:0] mk, input int acc);
        exp_t e;
        e.resp = cap_inv ? ~p : p;
        e.due  = acc + LAT;
        e.fl   = |((e.resp ^ ex) & mk);
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [N-1:0] p, input logic [N-1:0] ex,
                            input logic [N-1:0] mk, output int acc);
        @(negedge clk);
        pattern  = p;
        expected = ex;
        mask     = mk;
        start    = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        push_exp(p, ex, mk, acc);
        @(negedge clk);
        start    = 1'b0;
        pattern  = ~p;
        expected = ~ex;
        mask     = ~mk;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int a1;
        int a2;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_se", int'(scan_se), 0);
        nreset = 1'b1;
        @(negedge clk);
        #1;
        chk("init_busy", int'(busy), 0);
        chk("init_done", int'(done), 0);
        chk("init_se", int'(scan_se), 0);
        chk("init_si", int'(scan_si), 0);
        chk("init_response", int'(response), 0);

        // Inverting capture
        cap_inv = 1'b1;
        do_start(8'hA5, 8'h5A, 8'hFF, acc);
        #1;
        chk("busy_after_accept", int'(busy), 1);
        drain();
        do_start(8'h3C, 8'h00, 8'h00, acc);
        drain();

        // Identity capture: LSB-first mapping
        cap_inv = 1'b0;
        do_start(8'h01, 8'h01, 8'hFF, acc);
        drain();
        do_start(8'h80, 8'h80, 8'hFF, acc);
        drain();

        // Start pulses while busy, including during the DONE cycle
        cap_inv = 1'b1;
        do_start(8'hC3, 8'h00, 8'h00, acc);
        while (cyc < acc + 3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + LAT) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Held start: back-to-back with one IDLE cycle between
        @(negedge clk);
        pattern = 8'h96;
        start   = 1'b1;
        @(posedge clk);
        #1;
        a1 = cyc;
        push_exp(8'h96, 8'h00, 8'h00, a1);
        a2 = a1 + LAT + 2;
        push_exp(8'h96, 8'h00, 8'h00, a2);
        while (cyc < a2) @(negedge clk);
        start = 1'b0;
        drain();

        // Reset during the 4th UNLOAD cycle
        do_start(8'h5A, 8'h00, 8'h00, acc);
        while (cyc < acc + N + CAPT + 3) @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("midrst_se", int'(scan_se), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_response", int'(response), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (2 * LAT) @(negedge clk);
        do_start(8'hFF, 8'h00, 8'h00, acc);
        drain();

`ifdef LA_SCANCTRL_COMPARE_EN
        do_start(8'hA5, 8'h5A, 8'hFF, acc);
        drain();
        do_start(8'hA5, 8'h5B, 8'h01, acc);
        drain();
        do_start(8'hA5, 8'h5B, 8'hFE, acc);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
